// File: rtl/md5_pkg.sv
// Shared constants and types for the MD5 block sequencing controller.
package md5_pkg;

    localparam int LEN_W = 61;
    localparam int BLK_W = 512;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_ACC,
        ST_PAD,
        ST_OUT
    } state_t;

endpackage

// File: rtl/md5_block_ctrl_if.sv
// Message block stream from the host into the MD5 controller.
interface md5_block_ctrl_if;
    import md5_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             in_last;
    logic [6:0]       in_bytes;

    modport master (output in_valid, in_data, in_last, in_bytes, input in_ready);
    modport slave  (input in_valid, in_data, in_last, in_bytes, output in_ready);

endinterface

// File: rtl/md5_pad.sv
// Combinational MD5 padding of a final block, producing the optional extra block.
module md5_pad
    import md5_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    input  logic [6:0]       n,
    input  logic [63:0]      bit_len,
    output logic [BLK_W-1:0] main_blk,
    output logic             extra,
    output logic [BLK_W-1:0] extra_blk
);

    always_comb begin
        main_blk  = '0;
        extra_blk = '0;
        extra     = 1'b0;
        for (int j = 0; j < 64; j++) begin
            if (7'(j) < n) begin
                main_blk[8*j +: 8] = blk[8*j +: 8];
            end else if (7'(j) == n) begin
                main_blk[8*j +: 8] = 8'h80;
            end
        end
        // No room for the length field once the 0x80 marker lands past byte 55.
        if (n <= 7'd55) begin
            main_blk[511:448] = bit_len;
        end else begin
            extra              = 1'b1;
            extra_blk[511:448] = bit_len;
            if (n == 7'd64) begin
                extra_blk[7:0] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/md5_block_ctrl.sv
// MD5 message sequencer: pads the final block, drives the compression core and
// accumulates the chaining state into the digest.
module md5_block_ctrl
    import md5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    md5_block_ctrl_if.slave  blk_if,
    output logic             core_start,
    output logic [BLK_W-1:0] core_blk,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    output logic [31:0]      core_c,
    output logic [31:0]      core_d,
    input  logic             core_done,
    input  logic [31:0]      core_ra,
    input  logic [31:0]      core_rb,
    input  logic [31:0]      core_rc,
    input  logic [31:0]      core_rd,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic [127:0]     digest,
    output logic             busy
);

    state_t           state, state_nx;
    logic             start_q, busy_q, last_q, extra_pend;
    logic [LEN_W-1:0] len_q, len_sum;
    logic [6:0]       n_eff;
    logic [BLK_W-1:0] blk_q, extra_blk_q, pad_main, pad_extra_blk;
    logic             pad_extra;
    logic [31:0]      a_q, b_q, c_q, d_q, ra_q, rb_q, rc_q, rd_q;
    logic             accept, done_ok;

    assign n_eff   = !blk_if.in_last ? 7'd64 :
                     (blk_if.in_bytes > 7'd64) ? 7'd64 : blk_if.in_bytes;
    assign len_sum = len_q + LEN_W'(n_eff);

    md5_pad u_pad (
        .blk       (blk_if.in_data),
        .n         (n_eff),
        .bit_len   ({len_sum, 3'b000}),
        .main_blk  (pad_main),
        .extra     (pad_extra),
        .extra_blk (pad_extra_blk)
    );

    assign blk_if.in_ready = (state == ST_IDLE) && !rst;
    assign accept          = blk_if.in_valid && blk_if.in_ready;
    // The start cycle itself never counts as completion.
    assign done_ok         = (state == ST_RUN) && !start_q && core_done;

    always_comb begin
        state_nx     = state;
        digest_valid = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_RUN;
            ST_RUN:  if (done_ok) state_nx = ST_ACC;
            ST_ACC: begin
                if (extra_pend)  state_nx = ST_PAD;
                else if (last_q) state_nx = ST_OUT;
                else             state_nx = ST_IDLE;
            end
            ST_PAD:  state_nx = ST_RUN;
            ST_OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= (state != ST_RUN) && (state_nx == ST_RUN);
            if (accept)                              busy_q <= 1'b1;
            else if (state == ST_OUT && digest_ready) busy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= IV_A;
            b_q        <= IV_B;
            c_q        <= IV_C;
            d_q        <= IV_D;
            len_q      <= '0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            extra_pend <= 1'b0;
        end else begin
            if (accept) begin
                len_q       <= len_sum;
                last_q      <= blk_if.in_last;
                blk_q       <= blk_if.in_last ? pad_main : blk_if.in_data;
                extra_pend  <= blk_if.in_last && pad_extra;
                extra_blk_q <= pad_extra_blk;
            end
            if (done_ok) begin
                ra_q <= core_ra;
                rb_q <= core_rb;
                rc_q <= core_rc;
                rd_q <= core_rd;
            end
            if (state == ST_ACC) begin
                a_q <= a_q + ra_q;
                b_q <= b_q + rb_q;
                c_q <= c_q + rc_q;
                d_q <= d_q + rd_q;
            end
            if (state == ST_PAD) begin
                blk_q      <= extra_blk_q;
                extra_pend <= 1'b0;
            end
            if (state == ST_OUT && digest_ready) begin
                a_q   <= IV_A;
                b_q   <= IV_B;
                c_q   <= IV_C;
                d_q   <= IV_D;
                len_q <= '0;
            end
        end
    end

    assign core_start = start_q;
    assign core_blk   = blk_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_c     = c_q;
    assign core_d     = d_q;
    assign digest     = {d_q, c_q, b_q, a_q};
    assign busy       = busy_q;

endmodule

// File: doc/md5_block_ctrl.md
# md5_block_ctrl

Sequencing controller for the MD5 compression datapath. It accepts a message as a stream of 512-bit blocks and applies MD5 padding and the 64-bit length field to the final block, adding an extra block when needed. Each block is handed to the single-block compression core with the current chaining value. The block adds the core's result back into the chaining state (A..D) and presents the 128-bit digest once the message is complete. It sits between the message source (host/bus interface) and the compression core, and is the only master of that core.

## Interface
- IV_A, 32'h67452301, initial chaining word A
- IV_B, 32'hefcdab89, initial chaining word B
- IV_C, 32'h98badcfe, initial chaining word C
- IV_D, 32'h10325476, initial chaining word D
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  block offered
- in_ready  out  1  controller accepts block this cycle
- in_data  in  512  message bytes; byte j at bits [8j+7:8j]
- in_last  in  1  final block of message
- in_bytes  in  7  valid bytes in block (0..64); honoured only with in_last, else treated as 64
- core_start  out  1  one-cycle pulse: core latches core_blk and core_a..d
- core_blk  out  512  block to compress (padded where applicable), stable until core_done
- core_a/b/c/d  out  32 each  chaining input
- core_done  in  1  one-cycle pulse; core_ra..rd valid this cycle
- core_ra/rb/rc/rd  in  32 each  round output (before feed-forward add)
- digest_valid  out  1  digest available
- digest_ready  in  1  consumer takes digest
- digest  out  128  {D,C,B,A}; MD5 output byte 0 at bits [7:0]
- busy  out  1  high from first block accepted until digest taken

## Operation
- States: IDLE, RUN, ACC, PAD, OUT.
- IDLE: in_ready=1. On in_valid: register block, add byte count to 61-bit length counter (64 when not last). If last, apply padding. Then go to RUN.
- RUN: pulse core_start in the first cycle, then wait for core_done. On core_done, register core_r*. Go to ACC.
- ACC: A+=ra, B+=rb, C+=rc, D+=rd, all mod 2^32.
  - If an extra pad block is pending, go to PAD.
  - Else if the block was last, go to OUT.
  - Else go to IDLE.
- PAD: load the extra block, then go to RUN.
- OUT: digest_valid=1. On digest_ready, reload the IV, clear the length counter, and go to IDLE.
- Padding for a last block with n = in_bytes:
  - n ≤ 55: byte n = 0x80, bytes n+1..55 = 0, bits [511:448] = length·8 as a little-endian 64-bit value. One block.
  - 56 ≤ n ≤ 63: byte n = 0x80, remaining bytes 0. The extra block is all zero except the length field.
  - n = 64: block unmodified. The extra block has byte 0 = 0x80, zeros, and the length field.
  - n = 0: treated as the n ≤ 55 case (0x80 at byte 0).
- Bytes at index ≥ n in the last input block are ignored (forced to padding).
- The length counter wraps mod 2^61. The length field is the wrapped value ×8.

## Timing
- Reset values:
  - in_ready = 0 during rst, 1 on the first cycle after.
  - core_start = 0, digest_valid = 0, busy = 0.
  - core_blk = 0, digest = {IV_D, IV_C, IV_B, IV_A}.
  - A..D = IV, length counter = 0, state IDLE.
- Block acceptance occurs on in_valid & in_ready. core_start is asserted the following cycle.
- core_done is ignored outside RUN, and ignored in the core_start cycle itself.
- Controller overhead per block is 3 cycles plus core latency: accept, start, ACC.
- in_ready = 1 only in IDLE. There is no overlap between blocks.
- digest_valid is held, with digest stable, until digest_ready. Digest handoff with digest_ready already high completes in a single OUT cycle.
- rst mid-message aborts immediately. IV is reloaded, the counter is cleared, and a core_done arriving later is discarded.

## Structure
- Package md5_pkg: IV constants, the state enum, and the length/field width constants (LEN_W=61, BLK_W=512).
- Sub-module md5_pad: combinational padding of (block, n, bit length) into main block plus extra-block flag and extra block. The FSM and the adders stay in md5_block_ctrl.

## Test plan
- Empty message (in_last, in_bytes=0) -> core block = 0x80 at byte 0, rest 0. digest = d41d8cd98f00b204e9800998ecf8427e (byte order). Exactly one core_start.
- "abc" (n=3) -> digest 900150983cd24fb0d6963f7d28e17f72. bits [511:448] of core_blk = 24.
- 56-byte message -> two core_start pulses. The second block is all zero except length = 448.
- 64-byte full block then in_last with n=64 -> extra block with byte0 = 0x80 and length = 512. Digest matches the reference model.
- Two-block message, 120 bytes total:
  - in_ready is 0 while the first block is in RUN/ACC.
  - core_done injected during IDLE is ignored.
  - digest_ready is held low 5 cycles; digest stays valid and stable.
- rst asserted while waiting for core_done -> next cycle IDLE with A..D = IV. The stale core_done is ignored. A subsequent "abc" still yields the correct digest.
